// File: rtl/rf_wb_queue.sv
// Register-file write-back queue: in-order FIFO of pending writes with two
// forwarding lookup ports. Define WB_TRACE_EN to print each committed write.
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AW-1:0]                in_rd,
  input  logic                         in_link,
  input  logic [DW-1:0]                in_data,
  input  logic                         rf_hold,
  output logic                         rf_we,
  output logic [AW-1:0]                rf_waddr,
  output logic [DW-1:0]                rf_wdata,
  input  logic [AW-1:0]                fwd_addr1,
  output logic                         fwd_hit1,
  output logic [DW-1:0]                fwd_data1,
  input  logic [AW-1:0]                fwd_addr2,
  output logic                         fwd_hit2,
  output logic [DW-1:0]                fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [AW-1:0] eff_rd;
  logic          accept;
  logic          store;

  // jal links always land in r31; anything aimed at r0 is swallowed here
  assign eff_rd   = in_link ? AW'(31) : in_rd;
  assign accept   = in_valid && in_ready;
  assign store    = accept && (eff_rd != '0);

  assign empty    = (count == '0);
  assign in_ready = (count < CW'(DEPTH));
  assign rf_we    = !empty && !rf_hold;
  assign rf_waddr = rd_mem[rd_ptr];
  assign rf_wdata = data_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (rf_we) rd_ptr <= rd_ptr + PW'(1);
      case ({store, rf_we})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (store) begin
      rd_mem[wr_ptr]   <= eff_rd;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // Walks oldest to youngest so the last match found is the youngest one
  function automatic logic [DW:0] lookup(input logic [AW-1:0] addr);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (addr != '0) && (rd_mem[idx] == addr))
        res = {1'b1, data_mem[idx]};
    end
    return res;
  endfunction

  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    {fwd_hit1, fwd_data1} = lookup(fwd_addr1);
  end

  always_comb begin
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    {fwd_hit2, fwd_data2} = lookup(fwd_addr2);
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (rf_we) $display("r[%2d] = 0x%8X,", rf_waddr, rf_wdata);
  end
`else
  // Trace disabled: the queue produces no simulation output
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: vector table for single writes plus a
// scoreboard that checks every RF write against the accepted-result order.
module tb_rf_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_link, rf_hold, rf_we;
  logic [4:0]  in_rd, rf_waddr, fwd_addr1, fwd_addr2;
  logic [31:0] in_data, rf_wdata, fwd_data1, fwd_data2;
  logic        fwd_hit1, fwd_hit2, empty;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  typedef struct {
    logic [4:0]  rd;
    logic        link;
    logic [31:0] data;
    logic        drop;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  wb_t  sb[$];
  wb_t  mon_e;
  vec_t vecs[6];

  rf_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_link(in_link), .in_data(in_data),
    .rf_hold(rf_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_addr1(fwd_addr1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_addr2(fwd_addr2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one result, waits (bounded) for acceptance, records the expected write
  task automatic applyStimulus(input logic [4:0] rd, input logic link, input logic [31:0] data);
    logic [4:0] eff;
    bit ok;
    in_valid = 1'b1; in_rd = rd; in_link = link; in_data = data;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    eff = link ? 5'd31 : rd;
    if (ok && eff != 5'd0) sb.push_back('{eff, data});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    bit done;
    done = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (empty && sb.size() == 0) begin done = 1; break; end
    end
    checkOutput("drain_done", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every write the DUT commits must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got r%0d=0x%0h expected no write at %0t",
                 rf_waddr, rf_wdata, $time);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("wb_addr", 32'(rf_waddr), 32'(mon_e.a));
        checkOutput("wb_data", rf_wdata, mon_e.d);
      end
    end
  end

  initial begin
    vecs[0] = '{5'd5,  1'b0, 32'h12345678, 1'b0, 5'd5,  32'h12345678};
    vecs[1] = '{5'd7,  1'b1, 32'h00400010, 1'b0, 5'd31, 32'h00400010};
    vecs[2] = '{5'd0,  1'b0, 32'hCAFEF00D, 1'b1, 5'd0,  32'h0};
    vecs[3] = '{5'd0,  1'b1, 32'h00400020, 1'b0, 5'd31, 32'h00400020};
    vecs[4] = '{5'd31, 1'b0, 32'hDEADBEEF, 1'b0, 5'd31, 32'hDEADBEEF};
    vecs[5] = '{5'd3,  1'b0, 32'h0000A5A5, 1'b0, 5'd3,  32'h0000A5A5};

    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_link = 1'b0; in_data = '0;
    rf_hold = 1'b0; fwd_addr1 = 5'd5; fwd_addr2 = 5'd31;
    #12;
    checkOutput("rst_we",    32'(rf_we),    32'd0);
    checkOutput("rst_empty", 32'(empty),    32'd1);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_count", 32'(count),    32'd0);
    checkOutput("rst_hit1",  32'(fwd_hit1), 32'd0);
    checkOutput("rst_hit2",  32'(fwd_hit2), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single results into an empty queue: commit one cycle after acceptance
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].link, vecs[i].data);
      @(negedge clk);
      if (vecs[i].drop) begin
        checkOutput("drop_we",    32'(rf_we), 32'd0);
        checkOutput("drop_count", 32'(count), 32'd0);
      end else begin
        checkOutput("tbl_we",   32'(rf_we),    32'd1);
        checkOutput("tbl_addr", 32'(rf_waddr), 32'(vecs[i].exp_addr));
        checkOutput("tbl_data", rf_wdata,      vecs[i].exp_data);
      end
      @(posedge clk); #1;
      checkOutput("tbl_empty", 32'(empty), 32'd1);
    end

    // Fill under hold, then four back-to-back writes in order
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(5'(i), 1'b0, 32'(i * 32'h11));
    @(negedge clk);
    checkOutput("full_count", 32'(count),    32'd4);
    checkOutput("full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rf_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("order_we",   32'(rf_we),    32'd1);
      checkOutput("order_addr", 32'(rf_waddr), 32'(i));
      if (i == 1) checkOutput("full_drain_ready", 32'(in_ready), 32'd0);
    end
    waitDrain(10);

    // Youngest-match forwarding across two writes to r9
    fwd_addr1 = 5'd9; fwd_addr2 = 5'd0;
    rf_hold = 1'b1;
    applyStimulus(5'd9, 1'b0, 32'h0000AAAA);
    applyStimulus(5'd9, 1'b0, 32'h0000BBBB);
    @(negedge clk);
    checkOutput("fwd_hit1",  32'(fwd_hit1), 32'd1);
    checkOutput("fwd_data1", fwd_data1,     32'h0000BBBB);
    checkOutput("fwd_hit2",  32'(fwd_hit2), 32'd0);
    @(posedge clk); #1;
    rf_hold = 1'b0;
    @(negedge clk);
    checkOutput("fwd_head_hit",  32'(fwd_hit1), 32'd1);
    checkOutput("fwd_head_data", fwd_data1,     32'h0000BBBB);
    @(negedge clk);
    checkOutput("fwd_one_hit",  32'(fwd_hit1), 32'd1);
    checkOutput("fwd_one_data", fwd_data1,     32'h0000BBBB);
    @(negedge clk);
    checkOutput("fwd_none_hit", 32'(fwd_hit1), 32'd0);
    waitDrain(10);

    // Steady state at count=3: accept and drain every cycle across pointer wraps
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(5'(10 + i), 1'b0, 32'h0000_0A00 + 32'(i));
    rf_hold = 1'b0;
    for (int j = 0; j < 10; j++) begin
      applyStimulus(5'(1 + j), 1'b0, 32'h0000_0100 + 32'(j));
      checkOutput("steady_count", 32'(count), 32'd3);
    end
    waitDrain(12);

    // Reset while draining discards everything pending
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(5'(20 + i), 1'b0, 32'h0000_0C00 + 32'(i));
    fwd_addr1 = 5'd21; fwd_addr2 = 5'd22;
    rf_hold = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_we", 32'(rf_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_we",    32'(rf_we),    32'd0);
    checkOutput("mid_rst_count", 32'(count),    32'd0);
    checkOutput("mid_rst_hit1",  32'(fwd_hit1), 32'd0);
    checkOutput("mid_rst_hit2",  32'(fwd_hit2), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("post_rst_we", 32'(rf_we), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
- Write-back side of the register file: accepts results from execute/memory over a valid/ready handshake, buffers them in a small in-order FIFO, and drains one register write per cycle to the RF write port (we/waddr/wdata).
- Provides two forwarding lookup ports, so decode sees pending (not yet written) values for rs/rt.
- Link results (jal) are steered to r31 here; writes to r0 are discarded at entry.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  producer has a result
in_ready  out  1  queue can accept (count < DEPTH)
in_rd  in  AW  destination register
in_link  in  1  result is a jal link value; destination forced to 31
in_data  in  DW  result data
rf_hold  in  1  RF port busy; suppresses drain this cycle
rf_we  out  1  register write strobe
rf_waddr  out  AW  write address (head entry)
rf_wdata  out  DW  write data (head entry)
fwd_addr1  in  AW  lookup address, port 1 (rs)
fwd_hit1  out  1  pending write to fwd_addr1 exists
fwd_data1  out  DW  youngest pending data for fwd_addr1
fwd_addr2, fwd_hit2, fwd_data2  as port 1 (rt)
count  out  $clog2(DEPTH+1)  occupancy
empty  out  1  count == 0

Behaviour:
- Reset: rst asynchronous, active-high. Clears rd_ptr, wr_ptr and count to 0. rf_we=0, empty=1, in_ready=1, fwd_hit*=0. Entry payloads are not cleared. Reset mid-drain discards all pending entries.
- Accept: a transfer occurs when in_valid && in_ready on a clock edge.
  - Effective rd = in_link ? 31 : in_rd.
  - Effective rd == 0: handshake completes, nothing is stored, count unchanged.
  - Otherwise {rd, data} is written at wr_ptr and wr_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH). It is combinational from count only and does not depend on the same-cycle drain. A full queue therefore stalls the producer for at least one cycle.
- Drain (combinational outputs from the head entry):
  - rf_we = !empty && !rf_hold.
  - rf_waddr and rf_wdata always reflect the head entry; they are don't-care when empty.
  - On an edge with rf_we=1, rd_ptr increments modulo DEPTH.
- Latency: a result accepted into an empty queue at edge N drives rf_we during cycle N+1, and the RF commits at edge N+1.
- Count:
  - Accept-and-store with drain on the same edge: count unchanged.
  - Accept-and-store only: +1.
  - Drain only: -1.
  - Pointers wrap at DEPTH.
- Ordering: strict FIFO. Two pending writes to the same register drain oldest first.
- Forwarding (combinational, per port):
  - Scan all occupied entries, including the head being drained this cycle.
  - hit = any entry whose rd == fwd_addr. data = the youngest matching entry (closest to wr_ptr).
  - fwd_addr == 0 never hits.
  - The in-flight input (not yet accepted) is not forwarded.
- rf_hold held high: the queue fills to DEPTH, in_ready drops, and contents remain intact and forwardable.

Optional Feature:
WB_TRACE_EN
- Defined: on each edge with rf_we=1, print "r[%2d] = 0x%8X," with the rf_waddr and rf_wdata values.
- Undefined: no simulation output; RTL is otherwise identical.

Test Plan:
- Reset, then accept {rd=5, data=0x12345678}. Required: at the next cycle rf_we=1, waddr=5, wdata=0x12345678; then empty=1.
- in_link=1, in_rd=7, data=0x00400010. Required: rf_waddr=31, wdata=0x00400010. Separately, in_rd=0 with in_link=0: handshake completes, count stays 0, and rf_we never asserts.
- rf_hold=1 with back-to-back accepts of rd=1..4 (data 0x11,0x22,0x33,0x44). Required: count=4 and in_ready=0. Release hold: four writes in order rd 1,2,3,4 on consecutive cycles.
- With hold, enqueue {rd=9, 0xAAAA} then {rd=9, 0xBBBB}. Required: fwd_addr1=9 gives hit=1, data=0xBBBB, and fwd_addr2=0 gives hit=0. Release hold: after the first drain, hit=1 with data=0xBBBB; after the second, hit=0.
- At count=3 (DEPTH=4, hold=0), simultaneous accept and drain. Required: count stays 3, and pointers wrap correctly across 8+ transfers with no loss or reorder.
- Assert rst with 3 entries pending mid-drain. Required: immediately rf_we=0, count=0, fwd_hit*=0, and no further writes after rst deasserts.
